// File: rtl/slider_operand_entry_pkg.sv
// Shared types and step-constant helpers for the calculator operand entry.
package calc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    REPEAT
  } entry_state_t;

  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  // Deltas past the operand range are pre-reduced so they fit the datapath.
  function automatic longint unsigned step_delta(
    input int n,
    input longint unsigned maxv,
    input bit wrap
  );
    longint unsigned p;
    p = pow10(n);
    if (wrap) return p % (maxv + 1);
    return (p > maxv) ? maxv + 1 : p;
  endfunction

endpackage

// File: rtl/slider_operand_entry_if.sv
// Slider/operand bundle between the input conditioning and the entry block.
interface slider_operand_entry_if #(
  parameter int NUM_DIGITS    = 4,
  parameter int NUM_OPERANDS  = 2,
  parameter int OPERAND_WIDTH = 14
);
  localparam int SEL_W =
    (NUM_OPERANDS > 1) ? $clog2(NUM_OPERANDS) : 1;

  logic [NUM_DIGITS-1:0]                slider;
  logic [SEL_W-1:0]                     operand_sel;
  logic                                 decrement;
  logic                                 clear;
  logic [NUM_OPERANDS*OPERAND_WIDTH-1:0] operands;
  logic                                 step_pulse;

  modport master (
    output slider,
    output operand_sel,
    output decrement,
    output clear,
    input  operands,
    input  step_pulse
  );

  modport slave (
    input  slider,
    input  operand_sel,
    input  decrement,
    input  clear,
    output operands,
    output step_pulse
  );
endinterface

// File: rtl/slider_operand_entry_timer.sv
// Hold/auto-repeat timer: tracks the active slider and strobes step.
module hold_repeat_timer
  import calc_pkg::*;
#(
  parameter int HOLD_CYCLES   = 32500000,
  parameter int REPEAT_CYCLES = 8125000,
  parameter int NUM_DIGITS    = 4,
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_DIGITS-1:0] slider,
  output logic                  step,
  output logic [IW-1:0]         idx
);
  localparam int MAXC =
    (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  entry_state_t  st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [IW-1:0] idx_n, act;
  logic          any, same;

  always_comb begin
    act = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--)
      if (slider[i]) act = IW'(i);
  end

  assign any  = |slider;
  assign same = any && (act == idx);

  always_ff @(posedge clk) begin
    if (rst) begin
      st  <= IDLE;
      cnt <= '0;
      idx <= '0;
    end else begin
      st  <= st_n;
      cnt <= cnt_n;
      idx <= idx_n;
    end
  end

  always_comb begin
    st_n  = st;
    cnt_n = cnt;
    idx_n = idx;
    if (!any) begin
      st_n  = IDLE;
      cnt_n = '0;
    end else if (st == IDLE || act != idx) begin
      st_n  = ARMED;
      cnt_n = CW'(1);
      idx_n = act;
    end else if (step) begin
      st_n  = REPEAT;
      cnt_n = CW'(1);
    end else begin
      cnt_n = cnt + CW'(1);
    end
  end

  // ARMED fires on the edge sampling the HOLD_CYCLES-th active cycle.
  always_comb begin
    step = 1'b0;
    unique case (st)
      ARMED:   step = same && (cnt == CW'(HOLD_CYCLES - 1));
      REPEAT:  step = same && (cnt == CW'(REPEAT_CYCLES));
      default: step = 1'b0;
    endcase
  end
endmodule

// File: rtl/slider_operand_entry.sv
// Operand registers with saturating/wrapping decimal steps and clear.
module slider_operand_entry
  import calc_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int NUM_OPERANDS  = 2,
  parameter int OPERAND_WIDTH = 14,
  parameter int MAX_VALUE     = 9999,
  parameter int HOLD_CYCLES   = 32500000,
  parameter int REPEAT_CYCLES = 8125000,
  parameter int WRAP          = 0
) (
  input logic                  clk,
  input logic                  rst,
  slider_operand_entry_if.slave bus
);
  localparam int W  = OPERAND_WIDTH;
  localparam int W1 = OPERAND_WIDTH + 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SW = (NUM_OPERANDS > 1) ? $clog2(NUM_OPERANDS) : 1;
  localparam logic [W1-1:0] MAXV  = W1'(MAX_VALUE);
  localparam logic [W1-1:0] MAXV1 = W1'(MAX_VALUE + 1);

  logic [W-1:0]  ops [NUM_OPERANDS];
  logic [W1-1:0] delta_tab [NUM_DIGITS];
  logic [W-1:0]  cur, nxt;
  logic [W1-1:0] v, d, sum, nxt_w;
  logic [IW-1:0] idx;
  logic          step, sel_ok;
  logic          pulse;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_delta
    assign delta_tab[i] =
      W1'(step_delta(i, longint'(MAX_VALUE), WRAP != 0));
  end

  hold_repeat_timer #(
    .HOLD_CYCLES  (HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES),
    .NUM_DIGITS   (NUM_DIGITS)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .slider(bus.slider),
    .step  (step),
    .idx   (idx)
  );

  always_comb begin
    cur    = '0;
    sel_ok = 1'b0;
    for (int k = 0; k < NUM_OPERANDS; k++)
      if (bus.operand_sel == SW'(k)) begin
        cur    = ops[k];
        sel_ok = 1'b1;
      end
  end

  always_comb begin
    v   = {1'b0, cur};
    d   = delta_tab[idx];
    sum = v + d;
    if (!bus.decrement)
      nxt_w = (sum > MAXV) ?
        ((WRAP != 0) ? sum - MAXV1 : MAXV) : sum;
    else
      nxt_w = (d > v) ?
        ((WRAP != 0) ? v + MAXV1 - d : '0) : v - d;
    nxt = W'(nxt_w);
  end

  // Clear wins over a step landing in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_OPERANDS; k++) ops[k] <= '0;
      pulse <= 1'b0;
    end else begin
      pulse <= 1'b0;
      for (int k = 0; k < NUM_OPERANDS; k++)
        if (bus.operand_sel == SW'(k)) begin
          if (bus.clear) begin
            ops[k] <= '0;
            pulse  <= 1'b1;
          end else if (step) begin
            ops[k] <= nxt;
            pulse  <= 1'b1;
          end
        end
    end
  end

  for (genvar k = 0; k < NUM_OPERANDS; k++) begin : g_out
    assign bus.operands[k*W +: W] = ops[k];
  end

  assign bus.step_pulse = pulse & 1'b1;

  logic unused_ok;
  assign unused_ok = sel_ok;
endmodule
